// File: rtl/cells_pkg.sv
// Shared types for the cells frame sequencer: frame width, frame type and FSM state encoding.
package cells_pkg;

  localparam int CELL_FRAME_W = 16;

  typedef logic [CELL_FRAME_W-1:0] cell_frame_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STARVED = 2'd2
  } cells_seq_state_t;

endpackage

// File: rtl/cells_frame_fifo.sv
// Frame FIFO for the sequencer: storage, pointers, registered full flag, level.
// CELLS_SEQ_LOOP_EN adds a play pointer that can replay [rd_ptr, wr_ptr) without freeing entries.
module cells_frame_fifo
  import cells_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  cell_frame_t              push_data,
  input  logic                     pop,
  input  logic                     loop_mode,
  output cell_frame_t              head,
  output logic                     avail,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  cell_frame_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_next;
  logic [PW-1:0] rd_ptr_next;
  logic          full_reg;

  assign wr_ptr_next = wr_ptr + PW'(push);
  assign full        = full_reg;
  assign level       = wr_ptr - rd_ptr;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

`ifdef CELLS_SEQ_LOOP_EN
  logic [PW-1:0] play_ptr;
  logic [PW-1:0] play_inc;
  logic [PW-1:0] play_ptr_next;

  assign play_inc = play_ptr + PW'(1);

  // Outside loop mode rd_ptr follows play_ptr, freeing anything already replayed.
  always_comb begin
    rd_ptr_next   = rd_ptr;
    play_ptr_next = play_ptr;
    if (loop_mode) begin
      if (pop) begin
        play_ptr_next = (play_inc == wr_ptr) ? rd_ptr : play_inc;
      end
    end else begin
      play_ptr_next = pop ? play_inc : play_ptr;
      rd_ptr_next   = play_ptr_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      play_ptr <= '0;
    end else begin
      play_ptr <= play_ptr_next;
    end
  end

  assign avail = loop_mode ? (rd_ptr != wr_ptr) : (play_ptr != wr_ptr);
  assign head  = mem[play_ptr[AW-1:0]];
`else
  logic unused_loop_mode;

  assign unused_loop_mode = loop_mode;
  assign rd_ptr_next      = rd_ptr + PW'(pop);
  assign avail            = (rd_ptr != wr_ptr);
  // Head is read asynchronously so a pop lands in cells_state one cycle later.
  assign head             = mem[rd_ptr[AW-1:0]];
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      full_reg <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_next;
      rd_ptr   <= rd_ptr_next;
      full_reg <= (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                  (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
    end
  end

endmodule

// File: rtl/cells_frame_sequencer.sv
// Buffers host frames and plays them to cells_controller, advancing after repeat_count+1 scans.
// Optional replay of the buffer is enabled by defining CELLS_SEQ_LOOP_EN.
module cells_frame_sequencer
  import cells_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int REP_W = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   wr_valid,
  input  logic [15:0]            wr_data,
  output logic                   wr_ready,
  input  logic                   start,
  input  logic                   stop,
  input  logic [REP_W-1:0]       repeat_count,
  input  logic                   loop_mode,
  input  logic                   update_done,
  output logic [15:0]            cells_state,
  output logic                   system_enable_n,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   frame_done,
  output logic                   underflow
);

  cells_seq_state_t state_reg, state_next;
  cell_frame_t      frame_reg;
  cell_frame_t      head;
  logic [REP_W-1:0] rep_reg, rep_next;
  logic             update_done_q;
  logic             frame_done_reg, frame_done_next;
  logic             underflow_reg, underflow_next;
  logic             avail;
  logic             full;
  logic             pop;
  logic             push;
  logic             scan_edge;

  assign scan_edge = update_done && !update_done_q;
  assign push      = wr_valid && !full;

  cells_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .loop_mode (loop_mode),
    .head      (head),
    .avail     (avail),
    .full      (full),
    .level     (fifo_level)
  );

  // stop outranks start and scan edges; underflow set outranks the start clear.
  always_comb begin
    state_next      = state_reg;
    rep_next        = rep_reg;
    frame_done_next = 1'b0;
    underflow_next  = underflow_reg;
    pop             = 1'b0;
    if (stop) begin
      state_next = IDLE;
    end else begin
      if (start) begin
        underflow_next = 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (start && avail) begin
            pop        = 1'b1;
            state_next = RUN;
          end
        end
        RUN: begin
          if (scan_edge) begin
            if (rep_reg != '0) begin
              rep_next = rep_reg - REP_W'(1);
            end else begin
              frame_done_next = 1'b1;
              if (avail) begin
                pop = 1'b1;
              end else begin
                state_next     = STARVED;
                underflow_next = 1'b1;
              end
            end
          end
        end
        STARVED: begin
          if (scan_edge && avail) begin
            pop        = 1'b1;
            state_next = RUN;
          end
        end
        default: state_next = IDLE;
      endcase
      if (pop) begin
        rep_next = repeat_count;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      frame_reg      <= '0;
      rep_reg        <= '0;
      update_done_q  <= 1'b0;
      frame_done_reg <= 1'b0;
      underflow_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rep_reg        <= rep_next;
      update_done_q  <= update_done;
      frame_done_reg <= frame_done_next;
      underflow_reg  <= underflow_next;
      if (pop) begin
        frame_reg <= head;
      end
    end
  end

  assign cells_state     = frame_reg;
  assign system_enable_n = (state_reg == IDLE);
  assign busy            = (state_reg != IDLE);
  assign frame_done      = frame_done_reg;
  assign underflow       = underflow_reg;
  assign wr_ready        = !full;

endmodule

// File: tb/tb_cells_frame_sequencer.sv
// Self-checking bench for cells_frame_sequencer: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_cells_frame_sequencer;
  import cells_pkg::*;

  localparam int DEPTH = 8;
  localparam int REP_W = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             wr_valid = 1'b0;
  logic [15:0]      wr_data = '0;
  logic             wr_ready;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [REP_W-1:0] repeat_count = '0;
  logic             loop_mode = 1'b0;
  logic             update_done = 1'b0;
  logic [15:0]      cells_state;
  logic             system_enable_n;
  logic             busy;
  logic [LW-1:0]    fifo_level;
  logic             frame_done;
  logic             underflow;

  cells_frame_sequencer #(.DEPTH(DEPTH), .REP_W(REP_W)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .wr_valid        (wr_valid),
    .wr_data         (wr_data),
    .wr_ready        (wr_ready),
    .start           (start),
    .stop            (stop),
    .repeat_count    (repeat_count),
    .loop_mode       (loop_mode),
    .update_done     (update_done),
    .cells_state     (cells_state),
    .system_enable_n (system_enable_n),
    .busy            (busy),
    .fifo_level      (fifo_level),
    .frame_done      (frame_done),
    .underflow       (underflow)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: a frame queue plus "playing" / "starved" flags.
  logic [15:0] q[$];
  logic [15:0] m_cells = '0;
  int          m_rep = 0;
  bit          m_active = 0;
  bit          m_starved = 0;
  bit          m_under = 0;
  bit          m_fd = 0;
  bit          m_ud_prev = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic take();
    m_cells = q.pop_front();
    m_rep   = int'(repeat_count);
    $display("pop frame %h, %0d extra scans", m_cells, m_rep);
  endtask

  task automatic model_update();
    bit edge_seen, can_take, accept;
    m_fd = 0;
    if (!reset_n) begin
      q.delete();
      m_cells = '0; m_rep = 0; m_active = 0; m_starved = 0; m_under = 0; m_ud_prev = 0;
      return;
    end
    accept    = wr_valid && (q.size() < DEPTH);
    edge_seen = update_done && !m_ud_prev;
    m_ud_prev = update_done;
    can_take  = q.size() > 0;
    if (stop) begin
      m_active  = 0;
      m_starved = 0;
    end else begin
      if (start) m_under = 0;
      if (!m_active) begin
        if (start && can_take) begin take(); m_active = 1; end
      end else if (m_starved) begin
        if (edge_seen && can_take) begin take(); m_starved = 0; end
      end else if (edge_seen) begin
        if (m_rep > 0) m_rep--;
        else begin
          m_fd = 1;
          if (can_take) take();
          else begin m_starved = 1; m_under = 1; end
        end
      end
    end
    if (accept) begin
      q.push_back(wr_data);
      $display("write frame %h accepted, level %0d", wr_data, q.size());
    end
  endtask

  task automatic compare_all();
    check_val("cells_state", 32'(cells_state), 32'(m_cells));
    check_val("system_enable_n", 32'(system_enable_n), 32'(!m_active));
    check_val("busy", 32'(busy), 32'(m_active));
    check_val("fifo_level", 32'(fifo_level), 32'(q.size()));
    check_val("frame_done", 32'(frame_done), 32'(m_fd));
    check_val("underflow", 32'(underflow), 32'(m_under));
    check_val("wr_ready", 32'(wr_ready), 32'(q.size() < DEPTH));
  endtask

  task automatic step(input bit use_model);
    @(posedge clock);
    model_update();
    #1;
    if (use_model) compare_all();
  endtask

  task automatic write_frame(input logic [15:0] d);
    wr_valid = 1'b1; wr_data = d;
    step(1);
    wr_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
  endtask

  initial begin
    bit loop_rand;
    // Reset values
    step(1);
    reset_n = 1'b1;
    check_val("rst_cells_state", 32'(cells_state), 32'h0);
    check_val("rst_sen", 32'(system_enable_n), 32'h1);
    check_val("rst_level", 32'(fifo_level), 32'h0);
    check_val("rst_wr_ready", 32'(wr_ready), 32'h1);

    // Two frames, one scan each; update_done held high 5 cycles
    write_frame(16'h0155);
    write_frame(16'h02AA);
    repeat_count = 0;
    start = 1'b1; step(1); start = 1'b0;
    check_val("t1_first_frame", 32'(cells_state), 32'h0155);
    update_done = 1'b1; step(1);
    check_val("t1_swap", 32'(cells_state), 32'h02AA);
    check_val("t1_frame_done", 32'(frame_done), 32'h1);
    repeat (4) step(1);
    update_done = 1'b0; step(1);

    // Last frame completes -> starved, then refill
    update_done = 1'b1; step(1);
    check_val("t3_underflow", 32'(underflow), 32'h1);
    check_val("t3_sen_low", 32'(system_enable_n), 32'h0);
    check_val("t3_held", 32'(cells_state), 32'h02AA);
    update_done = 1'b0; step(1);
    write_frame(16'h0001);
    update_done = 1'b1; step(1);
    check_val("t3_refill_swap", 32'(cells_state), 32'h0001);
    update_done = 1'b0; step(1);

    // repeat_count = 2: swap only after the 3rd rising edge
    stop = 1'b1; step(1); stop = 1'b0;
    repeat_count = 2;
    write_frame(16'h1111);
    write_frame(16'h2222);
    start = 1'b1; step(1); start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      update_done = 1'b1; step(1);
      check_val("t2_repeat", 32'(cells_state), (k == 3) ? 32'h2222 : 32'h1111);
      update_done = 1'b0; step(1);
    end

    // Fill to DEPTH, then a write during a pop cycle is refused
    do_reset();
    repeat_count = 0;
    for (int i = 0; i < DEPTH; i++) write_frame(16'hA000 + 16'(i));
    check_val("t4_full_ready", 32'(wr_ready), 32'h0);
    check_val("t4_full_level", 32'(fifo_level), 32'(DEPTH));
    wr_valid = 1'b1; wr_data = 16'hBEEF; start = 1'b1;
    step(1);
    wr_valid = 1'b0; start = 1'b0;
    check_val("t4_refused_level", 32'(fifo_level), 32'(DEPTH - 1));

    // stop beats a scan edge
    update_done = 1'b1; stop = 1'b1;
    step(1);
    stop = 1'b0; update_done = 1'b0;
    check_val("t5_sen", 32'(system_enable_n), 32'h1);
    check_val("t5_level", 32'(fifo_level), 32'(DEPTH - 1));
    check_val("t5_no_pop", 32'(cells_state), 32'hA000);
    step(1);

`ifdef CELLS_SEQ_LOOP_EN
    // Loop replay: A, B, A, B with no consumption
    do_reset();
    loop_mode = 1'b1;
    repeat_count = 0;
    wr_valid = 1'b1; wr_data = 16'h00AA; step(0);
    wr_data = 16'h00BB; step(0);
    wr_valid = 1'b0;
    start = 1'b1; step(0); start = 1'b0;
    check_val("loop_first", 32'(cells_state), 32'h00AA);
    for (int k = 1; k <= 3; k++) begin
      update_done = 1'b1; step(0);
      check_val("loop_seq", 32'(cells_state), (k % 2 == 1) ? 32'h00BB : 32'h00AA);
      check_val("loop_level", 32'(fifo_level), 32'h2);
      check_val("loop_underflow", 32'(underflow), 32'h0);
      update_done = 1'b0; step(0);
    end
    loop_mode = 1'b0;
    do_reset();
    loop_rand = 0;
`else
    loop_rand = 1;
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset_n      = ($urandom_range(0, 499) != 0);
      wr_valid     = ($urandom_range(0, 9) < 4);
      wr_data      = 16'($urandom);
      start        = ($urandom_range(0, 9) == 0);
      stop         = ($urandom_range(0, 39) == 0);
      repeat_count = REP_W'($urandom_range(0, 3));
      loop_mode    = loop_rand && ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) update_done = ~update_done;
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
